// File: rtl/autotype_sequencer_if.sv
// Control/status bundle between the autotype script sequencer and its host:
// start/abort requests in, core reset, onboard key presses and run status out.
interface autotype_sequencer_if;
  logic start;
  logic abort;
  logic cpu_n_reset;
  logic key_b;
  logic key_c;
  logic key_enter;
  logic busy;
  logic done;

  modport master (
    output start,
    output abort,
    input  cpu_n_reset,
    input  key_b,
    input  key_c,
    input  key_enter,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  abort,
    output cpu_n_reset,
    output key_b,
    output key_c,
    output key_enter,
    output busy,
    output done
  );
endinterface

// File: rtl/autotype_sequencer.sv
// Plays a fixed boot script into the computer core: a reset pulse, then B, C and
// three ENTER presses, each active phase followed by an equally long idle gap.
module autotype_sequencer #(
  parameter int unsigned STEP_CYCLES = 32'd8388608,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_reset,
  autotype_sequencer_if.slave  seq
);

  localparam int unsigned        TIMER_W    = (STEP_CYCLES > 32'd1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_CYCLES - 32'd1);
  localparam logic [2:0]         STEP_LAST  = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [2:0]         step_r;
  logic [2:0]         step_s;
  logic [TIMER_W-1:0] timer_r;
  logic [TIMER_W-1:0] timer_s;
  logic               launch_r;
  logic               go_s;
  logic               timer_end_s;

  logic cpu_n_reset_r, cpu_n_reset_s;
  logic key_b_r, key_b_s;
  logic key_c_r, key_c_s;
  logic key_enter_r, key_enter_s;
  logic busy_r, busy_s;
  logic done_r, done_s;

  // launch_r is only set for the first edge after reset release
  assign go_s        = seq.start | (launch_r & AUTO_START);
  assign timer_end_s = (timer_r == TIMER_LAST);

  // Next-state logic: phase sequencing, abort and (re)start handling
  always_comb begin
    state_s = state_r;
    step_s  = step_r;
    timer_s = timer_r;
    case (state_r)
      IDLE, DONE: begin
        if (go_s) begin
          state_s = ACTIVE;
          step_s  = 3'd0;
          timer_s = '0;
        end else begin
          state_s = state_r;
        end
      end
      ACTIVE: begin
        if (seq.abort) begin
          state_s = IDLE;
          step_s  = 3'd0;
          timer_s = '0;
        end else if (timer_end_s) begin
          state_s = GAP;
          timer_s = '0;
        end else begin
          timer_s = timer_r + TIMER_W'(1);
        end
      end
      GAP: begin
        if (seq.abort) begin
          state_s = IDLE;
          step_s  = 3'd0;
          timer_s = '0;
        end else if (timer_end_s) begin
          timer_s = '0;
          if (step_r == STEP_LAST) begin
            state_s = DONE;
          end else begin
            state_s = ACTIVE;
            step_s  = step_r + 3'd1;
          end
        end else begin
          timer_s = timer_r + TIMER_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        step_s  = 3'd0;
        timer_s = '0;
      end
    endcase
  end

  // Output decode from the next state so outputs move on the same edge as the state
  always_comb begin
    cpu_n_reset_s = 1'b1;
    key_b_s       = 1'b0;
    key_c_s       = 1'b0;
    key_enter_s   = 1'b0;
    busy_s        = 1'b0;
    done_s        = 1'b0;
    case (state_s)
      ACTIVE: begin
        busy_s = 1'b1;
        case (step_s)
          3'd0:             cpu_n_reset_s = 1'b0;
          3'd1:             key_b_s       = 1'b1;
          3'd2:             key_c_s       = 1'b1;
          3'd3, 3'd4, 3'd5: key_enter_s   = 1'b1;
          default:          cpu_n_reset_s = 1'b1;
        endcase
      end
      GAP:     busy_s = 1'b1;
      DONE:    done_s = 1'b1;
      IDLE:    busy_s = 1'b0;
      default: busy_s = 1'b0;
    endcase
  end

  // State, counters and registered outputs; reset holds the core in reset
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r       <= IDLE;
      step_r        <= 3'd0;
      timer_r       <= '0;
      launch_r      <= 1'b1;
      cpu_n_reset_r <= 1'b0;
      key_b_r       <= 1'b0;
      key_c_r       <= 1'b0;
      key_enter_r   <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      step_r        <= step_s;
      timer_r       <= timer_s;
      launch_r      <= 1'b0;
      cpu_n_reset_r <= cpu_n_reset_s;
      key_b_r       <= key_b_s;
      key_c_r       <= key_c_s;
      key_enter_r   <= key_enter_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
    end
  end

  assign seq.cpu_n_reset = cpu_n_reset_r;
  assign seq.key_b       = key_b_r;
  assign seq.key_c       = key_c_r;
  assign seq.key_enter   = key_enter_r;
  assign seq.busy        = busy_r;
  assign seq.done        = done_r;

endmodule

// File: tb/tb_autotype_sequencer.sv
// Directed bench for autotype_sequencer with STEP_CYCLES=4: one auto-start
// instance for the script, aborts and async reset, one manual-start instance.
module tb_autotype_sequencer;

  // output vector layout: {cpu_n_reset, key_b, key_c, key_enter, busy, done}
  localparam logic [5:0] O_RST  = 6'b0_000_00;
  localparam logic [5:0] O_IDLE = 6'b1_000_00;
  localparam logic [5:0] O_ACT0 = 6'b0_000_10;
  localparam logic [5:0] O_GAP  = 6'b1_000_10;
  localparam logic [5:0] O_ACTB = 6'b1_100_10;
  localparam logic [5:0] O_ACTC = 6'b1_010_10;
  localparam logic [5:0] O_ACTE = 6'b1_001_10;
  localparam logic [5:0] O_DONE = 6'b1_000_01;

  typedef struct packed {
    logic       start_in;
    logic [5:0] exp;
  } phase_vec_t;

  logic clk = 1'b0;
  logic n_reset_a;
  logic n_reset_m;
  int   errors = 0;
  int   checks = 0;
  phase_vec_t run_tbl [13];

  autotype_sequencer_if if_a ();
  autotype_sequencer_if if_m ();

  autotype_sequencer #(.STEP_CYCLES(4), .AUTO_START(1'b1)) dut_a (
    .clk     (clk),
    .n_reset (n_reset_a),
    .seq     (if_a)
  );

  autotype_sequencer #(.STEP_CYCLES(4), .AUTO_START(1'b0)) dut_m (
    .clk     (clk),
    .n_reset (n_reset_m),
    .seq     (if_m)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs_a();
    return {if_a.cpu_n_reset, if_a.key_b, if_a.key_c, if_a.key_enter, if_a.busy, if_a.done};
  endfunction

  function automatic logic [5:0] outs_m();
    return {if_m.cpu_n_reset, if_m.key_b, if_m.key_c, if_m.key_enter, if_m.busy, if_m.done};
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  initial begin
    run_tbl[0]  = '{1'b0, O_ACT0};
    run_tbl[1]  = '{1'b1, O_GAP};
    run_tbl[2]  = '{1'b0, O_ACTB};
    run_tbl[3]  = '{1'b0, O_GAP};
    run_tbl[4]  = '{1'b1, O_ACTC};
    run_tbl[5]  = '{1'b0, O_GAP};
    run_tbl[6]  = '{1'b0, O_ACTE};
    run_tbl[7]  = '{1'b1, O_GAP};
    run_tbl[8]  = '{1'b0, O_ACTE};
    run_tbl[9]  = '{1'b0, O_GAP};
    run_tbl[10] = '{1'b1, O_ACTE};
    run_tbl[11] = '{1'b0, O_GAP};
    run_tbl[12] = '{1'b0, O_DONE};

    if_a.start = 1'b0;
    if_a.abort = 1'b0;
    if_m.start = 1'b0;
    if_m.abort = 1'b0;
    n_reset_a  = 1'b1;
    n_reset_m  = 1'b1;
    #1;
    n_reset_a  = 1'b0;
    n_reset_m  = 1'b0;
    #1;
    check("reset_a", outs_a(), O_RST);
    check("reset_m", outs_m(), O_RST);

    // Manual-start instance: stays idle until a start pulse
    n_reset_m = 1'b1;
    tick(1);
    check("m_first_edge_idle", outs_m(), O_IDLE);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check($sformatf("m_idle_hold c%0d", i), outs_m(), O_IDLE);
    end
    if_m.start = 1'b1;
    tick(1);
    if_m.start = 1'b0;
    check("m_start_c0", outs_m(), O_ACT0);
    for (int i = 1; i < 4; i++) begin
      tick(1);
      check($sformatf("m_reset_c%0d", i), outs_m(), O_ACT0);
    end
    tick(1);
    check("m_gap_c4", outs_m(), O_GAP);

    // Auto-start instance: full script with ignored start pulses mid-run
    n_reset_a = 1'b1;
    tick(1);
    for (int p = 0; p < 12; p++) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("run p%0d c%0d", p, k), outs_a(), run_tbl[p].exp);
        if_a.start = run_tbl[p].start_in;
        tick(1);
      end
    end
    if_a.start = 1'b0;
    check("run_done_c48", outs_a(), run_tbl[12].exp);
    tick(2);
    check("done_hold", outs_a(), O_DONE);

    // Abort during step2 active, then rerun from step0
    if_a.start = 1'b1;
    tick(1);
    if_a.start = 1'b0;
    check("rerun_c0", outs_a(), O_ACT0);
    tick(17);
    check("step2_active", outs_a(), O_ACTC);
    if_a.abort = 1'b1;
    tick(1);
    if_a.abort = 1'b0;
    check("abort_step2", outs_a(), O_IDLE);
    if_a.abort = 1'b1;
    tick(1);
    if_a.abort = 1'b0;
    check("abort_in_idle", outs_a(), O_IDLE);
    if_a.start = 1'b1;
    tick(1);
    if_a.start = 1'b0;
    check("start_after_abort", outs_a(), O_ACT0);
    tick(5);
    check("gap0_c5", outs_a(), O_GAP);

    // start and abort together in GAP: abort wins
    if_a.start = 1'b1;
    if_a.abort = 1'b1;
    tick(1);
    if_a.start = 1'b0;
    if_a.abort = 1'b0;
    check("both_in_gap", outs_a(), O_IDLE);
    if_a.start = 1'b1;
    tick(1);
    if_a.start = 1'b0;
    check("run2_c0", outs_a(), O_ACT0);
    tick(47);
    check("run2_c47", outs_a(), O_GAP);
    tick(1);
    check("run2_done", outs_a(), O_DONE);
    if_a.abort = 1'b1;
    tick(1);
    if_a.abort = 1'b0;
    check("abort_in_done", outs_a(), O_DONE);

    // start and abort together in DONE: restart
    if_a.start = 1'b1;
    if_a.abort = 1'b1;
    tick(1);
    if_a.start = 1'b0;
    if_a.abort = 1'b0;
    check("both_in_done", outs_a(), O_ACT0);
    tick(33);
    check("step4_active", outs_a(), O_ACTE);

    // Asynchronous reset mid-step4, between clock edges
    #2;
    n_reset_a = 1'b0;
    #1;
    check("async_reset", outs_a(), O_RST);
    #2;
    n_reset_a = 1'b1;
    tick(1);
    check("replay_c0", outs_a(), O_ACT0);
    tick(4);
    check("replay_c4", outs_a(), O_GAP);
    tick(4);
    check("replay_c8", outs_a(), O_ACTB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
